// File: rtl/pipe_stage_reg.sv
// Generic CPU pipeline stage register: valid/ready handshake, optional 2-entry
// skid buffer, synchronous flush with bubble injection, saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned NOP_OPC = 0,
  parameter bit          SKID    = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stateT;

  stateT              state, stateNext;
  logic [OPC_W-1:0]   mainOpc, mainOpcNext, skidOpc, skidOpcNext;
  logic [DATA_W-1:0]  mainData, mainDataNext, skidData, skidDataNext;
  logic [CNT_W-1:0]   stallCnt;
  logic               outValidInt;
  logic               inXfer;
  logic               outXfer;

  assign outValidInt = (state != EMPTY);
  assign inXfer      = in_valid & in_ready;
  assign outXfer     = outValidInt & out_ready;

  // Next-state and entry-load decisions. Payload is only ever captured on an
  // input transfer, so an undriven bus while in_valid=0 cannot leak to out_*.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    stateNext    = state;
    mainOpcNext  = mainOpc;
    mainDataNext = mainData;
    skidOpcNext  = skidOpc;
    skidDataNext = skidData;

    case (state)
      EMPTY: begin
        if (inXfer) begin
          mainOpcNext  = in_opcode;
          mainDataNext = in_data;
          stateNext    = ONE;
        end
      end
      ONE: begin
        if (inXfer && outXfer) begin
          mainOpcNext  = in_opcode;
          mainDataNext = in_data;
        end else if (inXfer && SKID) begin
          skidOpcNext  = in_opcode;
          skidDataNext = in_data;
          stateNext    = FULL;
        end else if (outXfer) begin
          mainOpcNext  = '0;
          mainDataNext = '0;
          stateNext    = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain path can fire.
        if (outXfer) begin
          mainOpcNext  = skidOpc;
          mainDataNext = skidData;
          skidOpcNext  = '0;
          skidDataNext = '0;
          stateNext    = ONE;
        end
      end
      default: stateNext = EMPTY;
    endcase

    if (flush) begin
      stateNext    = EMPTY;
      mainOpcNext  = '0;
      mainDataNext = '0;
      skidOpcNext  = '0;
      skidDataNext = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the payload entries are reset as well, because the skid entry must
    // be observably cleared and a stale entry must never survive a reset.
    if (!rst_n) begin
      state    <= EMPTY;
      mainOpc  <= '0;
      mainData <= '0;
      skidOpc  <= '0;
      skidData <= '0;
      stallCnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state    <= stateNext;
      mainOpc  <= mainOpcNext;
      mainData <= mainDataNext;
      skidOpc  <= skidOpcNext;
      skidData <= skidDataNext;
      if (outValidInt && !out_ready && (stallCnt != {CNT_W{1'b1}}))
        stallCnt <= stallCnt + 1'b1;
    end
  end

  generate
    if (SKID) begin : gSkidReady
      // Registered ready: mirrors "state != FULL" without a path from out_ready.
      logic inReadyQ;
      always_ff @(posedge clk) begin
        if (!rst_n) inReadyQ <= 1'b1;
        else        inReadyQ <= (stateNext != FULL);
      end
      assign in_ready = inReadyQ;
    end else begin : gPassReady
      assign in_ready = out_ready | ~outValidInt;
    end
  endgenerate

  assign out_valid  = outValidInt;
  assign out_opcode = outValidInt ? mainOpc : OPC_W'(NOP_OPC);
  assign out_data   = outValidInt ? mainData : '0;
  assign occupancy  = 2'(state);
  assign stall_cnt  = stallCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid (default), pass-through (SKID=0) and
// 4-bit counter instances share stimulus; each section checks one instance.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [4:0]  in_opcode;
  logic [31:0] in_data;

  logic        inReady0, outValid0, inReady1, outValid1, inReady2, outValid2;
  logic [4:0]  outOpc0, outOpc1, outOpc2;
  logic [31:0] outData0, outData1, outData2;
  logic [1:0]  occ0, occ1, occ2;
  logic [15:0] stall0, stall1;
  logic [3:0]  stall2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .OPC_W(5), .NOP_OPC(0), .SKID(1'b1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady0),
    .in_opcode(in_opcode), .in_data(in_data), .flush(flush),
    .out_valid(outValid0), .out_ready(out_ready), .out_opcode(outOpc0),
    .out_data(outData0), .occupancy(occ0), .stall_cnt(stall0));

  pipe_stage_reg #(.DATA_W(32), .OPC_W(5), .NOP_OPC(0), .SKID(1'b0), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady1),
    .in_opcode(in_opcode), .in_data(in_data), .flush(flush),
    .out_valid(outValid1), .out_ready(out_ready), .out_opcode(outOpc1),
    .out_data(outData1), .occupancy(occ1), .stall_cnt(stall1));

  pipe_stage_reg #(.DATA_W(32), .OPC_W(5), .NOP_OPC(0), .SKID(1'b1), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady2),
    .in_opcode(in_opcode), .in_data(in_data), .flush(flush),
    .out_valid(outValid2), .out_ready(out_ready), .out_opcode(outOpc2),
    .out_data(outData2), .occupancy(occ2), .stall_cnt(stall2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] opc);
    in_valid  = 1'b1;
    in_opcode = opc;
    in_data   = 32'hA000_0000 | {27'd0, opc};
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_data = '0;

    // Reset then full-throughput stream
    tick(); tick();
    check("rst_valid", outValid0, 0);
    check("rst_opc", outOpc0, 0);
    check("rst_data", outData0, 0);
    check("rst_occ", occ0, 0);
    check("rst_stall", stall0, 0);
    check("rst_in_ready", inReady0, 1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(5'd3); tick();
    check("s1_valid", outValid0, 1);
    check("s1_opc", outOpc0, 3);
    check("s1_data", outData0, 32'hA000_0003);
    check("s1_occ", occ0, 1);
    drive(5'd4); tick();
    check("s2_opc", outOpc0, 4);
    check("s2_occ", occ0, 1);
    drive(5'd5); tick();
    check("s3_opc", outOpc0, 5);
    check("s3_occ", occ0, 1);
    check("s3_nsk_opc", outOpc1, 5);
    in_valid = 1'b0; tick();
    check("s_end_valid", outValid0, 0);
    check("s_end_opc", outOpc0, 0);
    check("s_end_data", outData0, 0);
    check("s_stall", stall0, 0);

    // Backpressure into the skid entry
    doReset();
    out_ready = 1'b0;
    drive(5'd7); tick();
    check("bp_opc7", outOpc0, 7);
    check("bp_occ1", occ0, 1);
    drive(5'd8); tick();
    check("bp_occ2", occ0, 2);
    check("bp_in_ready", inReady0, 0);
    check("bp_hold7", outOpc0, 7);
    check("bp_stall1", stall0, 1);
    drive(5'h1F); tick(); tick();
    check("bp_stall3", stall0, 3);
    check("bp_hold7b", outOpc0, 7);
    check("bp_data7", outData0, 32'hA000_0007);
    check("bp_occ2b", occ0, 2);
    in_valid = 1'b0; out_ready = 1'b1; #1;
    check("bp_out7", outOpc0, 7);
    tick();
    check("bp_out8", outOpc0, 8);
    check("bp_data8", outData0, 32'hA000_0008);
    check("bp_occ_after", occ0, 1);
    tick();
    check("bp_drained", outValid0, 0);
    check("bp_stall_final", stall0, 3);

    // Flush while FULL with a simultaneous input
    doReset();
    out_ready = 1'b0;
    drive(5'd7); tick();
    drive(5'd8); tick();
    check("fl_pre_occ", occ0, 2);
    flush = 1'b1; drive(5'd9); tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", outValid0, 0);
    check("fl_opc", outOpc0, 0);
    check("fl_data", outData0, 0);
    check("fl_occ", occ0, 0);
    check("fl_in_ready", inReady0, 1);
    check("fl_stall_kept", stall0, 2);
    out_ready = 1'b1; tick();
    check("fl_no9_valid", outValid0, 0);
    check("fl_no9_occ", occ0, 0);

    // SKID=0: combinational ready
    doReset();
    check("nsk_rst_ready", inReady1, 1);
    out_ready = 1'b0;
    drive(5'h12); tick();
    check("nsk_opc12", outOpc1, 5'h12);
    check("nsk_occ", occ1, 1);
    drive(5'h13); #1;
    check("nsk_ready0", inReady1, 0);
    out_ready = 1'b1; #1;
    check("nsk_ready1", inReady1, 1);
    check("nsk_still12", outOpc1, 5'h12);
    tick();
    check("nsk_opc13", outOpc1, 5'h13);
    check("nsk_data13", outData1, 32'hA000_0013);
    check("nsk_occ13", occ1, 1);
    in_valid = 1'b0; tick();
    check("nsk_empty", outValid1, 0);

    // 4-bit stall counter saturation
    doReset();
    out_ready = 1'b0;
    drive(5'd1); tick();
    in_valid = 1'b0;
    repeat (14) tick();
    check("sat_14", stall2, 14);
    tick();
    check("sat_15", stall2, 15);
    repeat (5) tick();
    check("sat_hold", stall2, 15);
    check("sat_valid", outValid2, 1);
    check("sat_opc", outOpc2, 1);

    // Reset while FULL
    doReset();
    out_ready = 1'b0;
    drive(5'd7); tick();
    drive(5'd8); tick();
    check("mr_occ2", occ0, 2);
    check("mr_stall1", stall0, 1);
    rst_n = 1'b0; in_valid = 1'b0; tick();
    rst_n = 1'b1;
    check("mr_valid", outValid0, 0);
    check("mr_occ", occ0, 0);
    check("mr_stall", stall0, 0);
    check("mr_in_ready", inReady0, 1);
    check("mr_opc", outOpc0, 0);
    out_ready = 1'b1; tick();
    check("mr_no_ghost", outValid0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
